blockmem_sequencer: RTL and testbench

Initiator for `blockmem`: it walks tile addresses for the A, D and B operand streams, fetches MESHUNITS tiles per stream per group, and presents them to the mesh over a valid/ready handshake. It accepts C result groups from the mesh over a second handshake and issues the tile writes back into `blockmem`. It sits between the top-level controller (command port) and the `blockmem`/mesh pair.

---
 rtl/blockmem_pkg.sv | 26 ++
 rtl/blockmem_sequencer_if.sv | 62 ++++++
 rtl/tile_addr_gen.sv | 45 ++++
 rtl/blockmem_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_blockmem_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/blockmem_pkg.sv
// Shared types and tile address arithmetic for the blockmem sequencer.
// Addresses are computed in 32 bits; callers truncate to their own width.
package blockmem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StPresent,
        StWaitRes,
        StDone
    } seq_state_e;

    function automatic logic [31:0] tile_align(input logic [31:0] base,
                                               input int unsigned tile_units);
        return base & ~(tile_units - 1);
    endfunction

    function automatic logic [31:0] tile_addr(input logic [31:0] base,
                                              input logic [31:0] group,
                                              input int unsigned idx,
                                              input int unsigned mesh_units,
                                              input int unsigned tile_units);
        return base + (group * mesh_units + idx) * tile_units;
    endfunction

endpackage

// File: rtl/blockmem_sequencer_if.sv
// Command, blockmem read/write and mesh operand/result signals of the sequencer.
// master is the sequencer side; slave is the controller/blockmem/mesh side.
interface blockmem_sequencer_if #(
    parameter int unsigned BITWIDTH  = 16,
    parameter int unsigned MESHUNITS = 4,
    parameter int unsigned TILEUNITS = 4,
    parameter int unsigned LENWIDTH  = 8
);
    logic                                                       cmd_valid;
    logic                                                       cmd_ready;
    logic [BITWIDTH-1:0]                                        cmd_a_base;
    logic [BITWIDTH-1:0]                                        cmd_d_base;
    logic [BITWIDTH-1:0]                                        cmd_b_base;
    logic [BITWIDTH-1:0]                                        cmd_c_base;
    logic [LENWIDTH-1:0]                                        cmd_rows;

    logic [MESHUNITS-1:0][BITWIDTH-1:0]                         A_tile_read_addrs;
    logic [MESHUNITS-1:0][BITWIDTH-1:0]                         D_tile_read_addrs;
    logic [MESHUNITS-1:0][BITWIDTH-1:0]                         B_tile_read_addrs;
    logic [MESHUNITS-1:0]                                       A_read_valid;
    logic [MESHUNITS-1:0]                                       D_read_valid;
    logic [MESHUNITS-1:0]                                       B_read_valid;
    logic signed [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0]   A;
    logic signed [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0]   D;
    logic signed [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0]   B;

    logic                                                       mesh_valid;
    logic                                                       mesh_ready;
    logic signed [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0]   mesh_A;
    logic signed [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0]   mesh_D;
    logic signed [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0]   mesh_B;

    logic                                                       res_valid;
    logic                                                       res_ready;
    logic [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0]          res_C;

    logic [MESHUNITS-1:0][BITWIDTH-1:0]                         C_tile_write_addrs;
    logic [MESHUNITS-1:0]                                       C_write_valid;
    logic [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0]          C;

    logic                                                       busy;
    logic                                                       done;

    modport master (
        input  cmd_valid, cmd_a_base, cmd_d_base, cmd_b_base, cmd_c_base, cmd_rows,
        input  A, D, B, mesh_ready, res_valid, res_C,
        output cmd_ready, A_tile_read_addrs, D_tile_read_addrs, B_tile_read_addrs,
        output A_read_valid, D_read_valid, B_read_valid,
        output mesh_valid, mesh_A, mesh_D, mesh_B, res_ready,
        output C_tile_write_addrs, C_write_valid, C, busy, done
    );

    modport slave (
        output cmd_valid, cmd_a_base, cmd_d_base, cmd_b_base, cmd_c_base, cmd_rows,
        output A, D, B, mesh_ready, res_valid, res_C,
        input  cmd_ready, A_tile_read_addrs, D_tile_read_addrs, B_tile_read_addrs,
        input  A_read_valid, D_read_valid, B_read_valid,
        input  mesh_valid, mesh_A, mesh_D, mesh_B, res_ready,
        input  C_tile_write_addrs, C_write_valid, C, busy, done
    );

endinterface

// File: rtl/tile_addr_gen.sv
// Per-stream tile address walker: holds the aligned base and group index and
// emits the MESHUNITS tile addresses of the current group.
module tile_addr_gen
    import blockmem_pkg::*;
#(
    parameter int unsigned BITWIDTH  = 16,
    parameter int unsigned MESHUNITS = 4,
    parameter int unsigned TILEUNITS = 4,
    parameter int unsigned LENWIDTH  = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               load,
    input  logic                               advance,
    input  logic [BITWIDTH-1:0]                base,
    output logic [LENWIDTH-1:0]                group,
    output logic [MESHUNITS-1:0][BITWIDTH-1:0] addrs
);

    logic [BITWIDTH-1:0] base_q;
    logic [LENWIDTH-1:0] group_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_q  <= '0;
            group_q <= '0;
        end else if (load) begin
            base_q  <= BITWIDTH'(tile_align(32'(base), TILEUNITS));
            group_q <= '0;
        end else if (advance) begin
            group_q <= group_q + 1'b1;
        end
    end

    // Truncation to BITWIDTH gives the silent modulo-2^BITWIDTH wrap.
    always_comb begin
        addrs = '0;
        for (int unsigned i = 0; i < MESHUNITS; i++) begin
            addrs[i] = BITWIDTH'(tile_addr(32'(base_q), 32'(group_q), i, MESHUNITS, TILEUNITS));
        end
    end

    assign group = group_q;

endmodule

// File: rtl/blockmem_sequencer.sv
// Fetches A/D/B tile groups from blockmem, presents them to the mesh, and
// writes returned C groups back to blockmem one cycle after each result accept.
module blockmem_sequencer
    import blockmem_pkg::*;
#(
    parameter int unsigned BITWIDTH  = 16,
    parameter int unsigned MESHUNITS = 4,
    parameter int unsigned TILEUNITS = 4,
    parameter int unsigned LENWIDTH  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    blockmem_sequencer_if.master bus
);

    seq_state_e state_q, state_d;

    logic [LENWIDTH-1:0] rows_q;
    logic [LENWIDTH-1:0] rd_cnt, wr_cnt, d_group, b_group;
    logic [LENWIDTH:0]   rd_next;
    logic                last_group;
    logic                cmd_hs, mesh_hs, res_hs;
    logic                fetch, busy;
    logic                wr_pend_q;
    logic                unused_groups;

    logic [MESHUNITS-1:0][BITWIDTH-1:0]                       a_addrs, d_addrs, b_addrs, c_addrs;
    logic [MESHUNITS-1:0][BITWIDTH-1:0]                       c_addrs_q;
    logic [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0]        c_q;
    logic signed [MESHUNITS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] mesh_a_q, mesh_d_q, mesh_b_q;

    assign cmd_hs     = (state_q == StIdle) && bus.cmd_valid;
    assign mesh_hs    = (state_q == StPresent) && bus.mesh_ready;
    assign res_hs     = bus.res_valid && bus.res_ready;
    assign rd_next    = {1'b0, rd_cnt} + 1'b1;
    assign last_group = rd_next >= {1'b0, rows_q};

    tile_addr_gen #(
        .BITWIDTH (BITWIDTH),
        .MESHUNITS(MESHUNITS),
        .TILEUNITS(TILEUNITS),
        .LENWIDTH (LENWIDTH)
    ) u_gen_a (
        .clock  (clock),
        .reset  (reset),
        .load   (cmd_hs),
        .advance(mesh_hs),
        .base   (bus.cmd_a_base),
        .group  (rd_cnt),
        .addrs  (a_addrs)
    );

    tile_addr_gen #(
        .BITWIDTH (BITWIDTH),
        .MESHUNITS(MESHUNITS),
        .TILEUNITS(TILEUNITS),
        .LENWIDTH (LENWIDTH)
    ) u_gen_d (
        .clock  (clock),
        .reset  (reset),
        .load   (cmd_hs),
        .advance(mesh_hs),
        .base   (bus.cmd_d_base),
        .group  (d_group),
        .addrs  (d_addrs)
    );

    tile_addr_gen #(
        .BITWIDTH (BITWIDTH),
        .MESHUNITS(MESHUNITS),
        .TILEUNITS(TILEUNITS),
        .LENWIDTH (LENWIDTH)
    ) u_gen_b (
        .clock  (clock),
        .reset  (reset),
        .load   (cmd_hs),
        .advance(mesh_hs),
        .base   (bus.cmd_b_base),
        .group  (b_group),
        .addrs  (b_addrs)
    );

    tile_addr_gen #(
        .BITWIDTH (BITWIDTH),
        .MESHUNITS(MESHUNITS),
        .TILEUNITS(TILEUNITS),
        .LENWIDTH (LENWIDTH)
    ) u_gen_c (
        .clock  (clock),
        .reset  (reset),
        .load   (cmd_hs),
        .advance(res_hs),
        .base   (bus.cmd_c_base),
        .group  (wr_cnt),
        .addrs  (c_addrs)
    );

    // D and B walk in lockstep with A, so A's group index serves as the read counter.
    assign unused_groups = ^{d_group, b_group};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            rows_q  <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_hs) rows_q <= bus.cmd_rows;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.cmd_ready  = 1'b0;
        bus.mesh_valid = 1'b0;
        bus.done       = 1'b0;
        busy           = 1'b1;
        fetch          = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy          = 1'b0;
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) state_d = (bus.cmd_rows == '0) ? StDone : StFetch;
            end
            StFetch: begin
                fetch   = 1'b1;
                state_d = StPresent;
            end
            StPresent: begin
                bus.mesh_valid = 1'b1;
                if (bus.mesh_ready) state_d = last_group ? StWaitRes : StFetch;
            end
            // The final write issues in the cycle wr_cnt reaches rows_q, so it
            // completes alongside this transition.
            StWaitRes: if (wr_cnt == rows_q) state_d = StDone;
            StDone: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy      = busy;
    assign bus.res_ready = busy && (wr_cnt < rows_q);

    assign bus.A_tile_read_addrs = fetch ? a_addrs : '0;
    assign bus.D_tile_read_addrs = fetch ? d_addrs : '0;
    assign bus.B_tile_read_addrs = fetch ? b_addrs : '0;
    assign bus.A_read_valid      = {MESHUNITS{fetch}};
    assign bus.D_read_valid      = {MESHUNITS{fetch}};
    assign bus.B_read_valid      = {MESHUNITS{fetch}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mesh_a_q <= '0;
            mesh_d_q <= '0;
            mesh_b_q <= '0;
        end else if (fetch) begin
            mesh_a_q <= bus.A;
            mesh_d_q <= bus.D;
            mesh_b_q <= bus.B;
        end
    end

    assign bus.mesh_A = mesh_a_q;
    assign bus.mesh_D = mesh_d_q;
    assign bus.mesh_B = mesh_b_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_pend_q <= 1'b0;
            c_q       <= '0;
            c_addrs_q <= '0;
        end else begin
            wr_pend_q <= res_hs;
            if (res_hs) begin
                c_q       <= bus.res_C;
                c_addrs_q <= c_addrs;
            end
        end
    end

    assign bus.C                  = c_q;
    assign bus.C_tile_write_addrs = c_addrs_q;
    assign bus.C_write_valid      = {MESHUNITS{wr_pend_q}};

endmodule

// File: tb/tb_blockmem_sequencer.sv
// Randomised directed bench for blockmem_sequencer with a transaction-level
// reference model of fetch, presentation, result write-back and completion.
module tb_blockmem_sequencer;

    localparam int BW = 16;
    localparam int MU = 2;
    localparam int TU = 4;
    localparam int LW = 8;

    logic clock = 1'b0;
    logic reset;
    logic [15:0] salt;
    int ntests = 0;
    int nfail  = 0;

    always #5 clock = ~clock;

    blockmem_sequencer_if #(.BITWIDTH(BW), .MESHUNITS(MU), .TILEUNITS(TU), .LENWIDTH(LW)) bus ();

    blockmem_sequencer #(.BITWIDTH(BW), .MESHUNITS(MU), .TILEUNITS(TU), .LENWIDTH(LW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Memory contents as a pure function of stream, address and word index.
    function automatic logic [15:0] mem_word(input int s, input logic [15:0] addr, input int w);
        logic [15:0] v;
        v = addr + 16'(w);
        return (v * 16'd31 + 16'(s * 7919)) ^ salt;
    endfunction

    always_comb begin
        for (int i = 0; i < MU; i++) begin
            for (int w = 0; w < TU; w++) begin
                bus.A[i][w] = mem_word(0, bus.A_tile_read_addrs[i], w);
                bus.D[i][w] = mem_word(1, bus.D_tile_read_addrs[i], w);
                bus.B[i][w] = mem_word(2, bus.B_tile_read_addrs[i], w);
            end
        end
    end

    function automatic logic [15:0] exp_addr(input logic [15:0] base, input int g, input int i);
        logic [15:0] al;
        al = base & ~16'(TU - 1);
        return al + 16'((g * MU + i) * TU);
    endfunction

    function automatic logic [MU*BW-1:0] exp_addrs(input logic [15:0] base, input int g);
        logic [MU*BW-1:0] r;
        for (int i = 0; i < MU; i++) r[i*BW +: BW] = exp_addr(base, g, i);
        return r;
    endfunction

    function automatic logic [127:0] exp_tile(input int s, input logic [15:0] base, input int g);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < MU; i++)
            for (int w = 0; w < TU; w++)
                r[(i*TU+w)*16 +: 16] = mem_word(s, exp_addr(base, g, i), w);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [15:0] a, input logic [15:0] d, input logic [15:0] b,
                           input logic [15:0] c, input logic [7:0] rows, input int stall,
                           input int abort_at);
        int rg, wg, h_last, w_last, done_cyc, next_fetch, wexp_cyc, wexp_grp, stalled;
        bit present, hs, rdy, finished, fetch_exp, busy_exp;
        logic [127:0] wexp_data, rdata;
        rg = 0; wg = 0; h_last = -1; w_last = -1; wexp_cyc = -1; wexp_grp = 0;
        stalled = 0; present = 0; finished = 0; wexp_data = '0;
        done_cyc   = (rows == 0) ? 1 : -1;
        next_fetch = (rows == 0) ? -1 : 1;
        @(negedge clock);
        salt = 16'($urandom);
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_a_base = a;
        bus.cmd_d_base = d;
        bus.cmd_b_base = b;
        bus.cmd_c_base = c;
        bus.cmd_rows   = rows;
        for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
            @(negedge clock);
            if (cyc == abort_at) begin
                bus.cmd_valid  = 1'b0;
                bus.res_valid  = 1'b0;
                bus.mesh_ready = 1'b0;
                reset = 1'b1;
                #1;
                chk("abort_mesh_valid", bus.mesh_valid, 0);
                chk("abort_busy", bus.busy, 0);
                chk("abort_C_write_valid", bus.C_write_valid, 0);
                chk("abort_A_read_valid", bus.A_read_valid, 0);
                chk("abort_res_ready", bus.res_ready, 0);
                @(negedge clock);
                reset = 1'b0;
                chk("abort_cmd_ready", bus.cmd_ready, 1);
                return;
            end
            fetch_exp = (cyc == next_fetch);
            busy_exp  = (done_cyc < 0) || (cyc <= done_cyc);
            chk("A_read_valid", bus.A_read_valid, fetch_exp ? 3 : 0);
            chk("D_read_valid", bus.D_read_valid, fetch_exp ? 3 : 0);
            chk("B_read_valid", bus.B_read_valid, fetch_exp ? 3 : 0);
            if (fetch_exp) begin
                chk("A_addrs", bus.A_tile_read_addrs, exp_addrs(a, rg));
                chk("D_addrs", bus.D_tile_read_addrs, exp_addrs(d, rg));
                chk("B_addrs", bus.B_tile_read_addrs, exp_addrs(b, rg));
            end
            chk("mesh_valid", bus.mesh_valid, present);
            if (present) begin
                chk("mesh_A", bus.mesh_A, exp_tile(0, a, rg));
                chk("mesh_D", bus.mesh_D, exp_tile(1, d, rg));
                chk("mesh_B", bus.mesh_B, exp_tile(2, b, rg));
            end
            chk("C_write_valid", bus.C_write_valid, (cyc == wexp_cyc) ? 3 : 0);
            if (cyc == wexp_cyc) begin
                chk("C_addrs", bus.C_tile_write_addrs, exp_addrs(c, wexp_grp));
                chk("C_data", bus.C, wexp_data);
            end
            chk("res_ready", bus.res_ready, busy_exp && (wg < int'(rows)));
            chk("busy", bus.busy, busy_exp);
            chk("cmd_ready", bus.cmd_ready, !busy_exp);
            chk("done", bus.done, cyc == done_cyc);

            // Stray commands while busy must be ignored.
            bus.cmd_valid  = (cyc != done_cyc) && ($urandom_range(0, 3) == 0);
            bus.cmd_a_base = 16'($urandom);
            bus.cmd_rows   = 8'($urandom);

            rdy = (stalled >= stall) && ($urandom_range(0, 2) != 0);
            if (present && stalled < stall) stalled++;
            bus.mesh_ready = rdy;
            hs = present && rdy;
            if (hs) begin
                rg++;
                h_last = cyc;
                if (rg < int'(rows)) next_fetch = cyc + 1;
            end
            present = (present && !hs) || fetch_exp;

            rdata = {$urandom, $urandom, $urandom, $urandom};
            bus.res_C = rdata;
            if (busy_exp && wg < int'(rows) && $urandom_range(0, 1) == 1) begin
                bus.res_valid = 1'b1;
                wexp_cyc  = cyc + 1;
                wexp_grp  = wg;
                wexp_data = rdata;
                wg++;
                if (wg == int'(rows)) w_last = cyc + 1;
            end else begin
                bus.res_valid = 1'b0;
            end

            if (done_cyc < 0 && rg == int'(rows) && wg == int'(rows))
                done_cyc = ((h_last + 1 > w_last) ? h_last + 1 : w_last) + 1;
            if (cyc == done_cyc) finished = 1;
        end
        chk("completed_in_bound", finished, 1);
        bus.cmd_valid  = 1'b0;
        bus.res_valid  = 1'b0;
        bus.mesh_ready = 1'b0;
        @(negedge clock);
        chk("post_cmd_ready", bus.cmd_ready, 1);
        chk("post_done", bus.done, 0);
        chk("post_busy", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", ntests);
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        salt           = 16'($urandom);
        bus.cmd_valid  = 1'b0;
        bus.cmd_a_base = '0;
        bus.cmd_d_base = '0;
        bus.cmd_b_base = '0;
        bus.cmd_c_base = '0;
        bus.cmd_rows   = '0;
        bus.mesh_ready = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_C      = '0;
        repeat (2) @(negedge clock);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_mesh_valid", bus.mesh_valid, 0);
        chk("rst_res_ready", bus.res_ready, 0);
        chk("rst_A_read_valid", bus.A_read_valid, 0);
        chk("rst_A_addrs", bus.A_tile_read_addrs, 0);
        chk("rst_B_addrs", bus.B_tile_read_addrs, 0);
        chk("rst_mesh_A", bus.mesh_A, 0);
        chk("rst_C_write_valid", bus.C_write_valid, 0);
        chk("rst_C_addrs", bus.C_tile_write_addrs, 0);
        chk("rst_C", bus.C, 0);
        reset = 1'b0;

        run_cmd(16'h0010, 16'h0200, 16'h0013, 16'h0040, 8'd1, 0, 0);
        run_cmd(16'hFFF8, 16'h1234, 16'hFFFF, 16'h0080, 8'd2, 0, 0);
        run_cmd(16'h0100, 16'h0300, 16'h0500, 16'h0700, 8'd3, 5, 0);
        run_cmd(16'h0020, 16'h0030, 16'h0050, 16'h0040, 8'd2, 0, 0);
        run_cmd(16'h0020, 16'h0030, 16'h0050, 16'h0040, 8'd0, 0, 0);
        for (int k = 0; k < 6; k++)
            run_cmd(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    8'($urandom_range(1, 6)), $urandom_range(0, 3), 0);
        run_cmd(16'h0400, 16'h0800, 16'h0C00, 16'h1000, 8'd3, 20, 4);
        run_cmd(16'h0404, 16'h0808, 16'h0C0C, 16'h1010, 8'd2, 1, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
